// File: rtl/tile_out_collector_if.sv
// ----------------------------------------------------------------------------
// tile_out_collector_if
// Groups the tile-side input signals and the consumer-side FIFO output
// signals of tile_out_collector into one bundle.
//   slave  : the collector (takes tile inputs and io_out_ready, drives outputs)
//   master : the environment (tile plus consumer)
// Signals:
//   io_in_c                 signed 136-bit accumulator result from the tile
//   io_in_control_propagate propagate flag accompanying the result
//   io_in_valid             result valid (no backpressure toward the tile)
//   io_out_valid            FIFO head entry valid
//   io_out_ready            consumer accepts the head entry
//   io_out_bits_data        saturated signed 32-bit result
//   io_out_bits_sat         saturation occurred on this entry
//   io_out_bits_row         row index of this entry within its block
//   io_out_bits_first       this entry is row 0 of a block
//   io_overflow             sticky flag, an input was dropped
//   io_count                current FIFO occupancy
// ----------------------------------------------------------------------------
interface tile_out_collector_if #(
    parameter int DEPTH = 4
);
    localparam int CW = $clog2(DEPTH) + 1;

    logic signed [135:0] io_in_c;
    logic                io_in_control_propagate;
    logic                io_in_valid;
    logic                io_out_valid;
    logic                io_out_ready;
    logic [31:0]         io_out_bits_data;
    logic                io_out_bits_sat;
    logic [3:0]          io_out_bits_row;
    logic                io_out_bits_first;
    logic                io_overflow;
    logic [CW-1:0]       io_count;

    modport master (
        output io_in_c, io_in_control_propagate, io_in_valid, io_out_ready,
        input  io_out_valid, io_out_bits_data, io_out_bits_sat,
               io_out_bits_row, io_out_bits_first, io_overflow, io_count
    );

    modport slave (
        input  io_in_c, io_in_control_propagate, io_in_valid, io_out_ready,
        output io_out_valid, io_out_bits_data, io_out_bits_sat,
               io_out_bits_row, io_out_bits_first, io_overflow, io_count
    );
endinterface

// File: rtl/tile_out_collector.sv
// ----------------------------------------------------------------------------
// tile_out_collector
// Collects results from a mesh tile, saturates them to signed 32 bits, tags
// each with its row index within the current block, and buffers them in a
// first-word-fall-through FIFO for a downstream consumer. The tile cannot be
// stalled, so an input arriving while the FIFO is full (and not popping) is
// dropped and a sticky overflow flag is raised.
// Ports:
//   clock  rising-edge clock
//   reset  synchronous active-high reset
//   bus    tile_out_collector_if.slave (tile inputs, FIFO outputs, status)
// Parameters:
//   DEPTH  FIFO entries (power of two, >= 2)
//   ROWS   rows per block; the row index wraps after ROWS-1
// ----------------------------------------------------------------------------
module tile_out_collector #(
    parameter int DEPTH = 4,
    parameter int ROWS  = 16
) (
    input  logic                 clock,
    input  logic                 reset,
    tile_out_collector_if.slave  bus
);
    localparam int PW = $clog2(DEPTH);
    localparam int CW = PW + 1;
    localparam int EW = 38;  // {first, row[3:0], sat, data[31:0]}

    logic [EW-1:0] r_mem [DEPTH];
    logic [PW-1:0] r_wr_ptr;
    logic [PW-1:0] r_rd_ptr;
    logic [CW-1:0] r_count;
    logic [3:0]    r_row;
    logic          r_prev_prop;
    logic          r_overflow;

    logic          w_pos_ovf;
    logic          w_neg_ovf;
    logic [31:0]   w_sat_data;
    logic          w_sat;
    logic [3:0]    w_entry_row;
    logic [3:0]    w_next_row;
    logic          w_full;
    logic          w_pop;
    logic          w_push;
    logic          w_drop;
    logic [EW-1:0] w_entry;
    logic [EW-1:0] w_head;

    // Out of range above: non-negative with any bit above bit 30 set.
    // Out of range below: negative with any bit above bit 30 clear.
    always_comb begin
        w_pos_ovf  = ~bus.io_in_c[135] & (|bus.io_in_c[134:31]);
        w_neg_ovf  =  bus.io_in_c[135] & ~(&bus.io_in_c[134:31]);
        w_sat      = w_pos_ovf | w_neg_ovf;
        w_sat_data = bus.io_in_c[31:0];
        if (w_pos_ovf) begin
            w_sat_data = 32'h7FFF_FFFF;
        end else if (w_neg_ovf) begin
            w_sat_data = 32'h8000_0000;
        end
    end

    // A change of the propagate flag marks the start of a new block.
    always_comb begin
        w_entry_row = r_row;
        if (bus.io_in_control_propagate != r_prev_prop) begin
            w_entry_row = '0;
        end
        w_next_row = w_entry_row + 4'd1;
        if (w_entry_row == 4'(ROWS - 1)) begin
            w_next_row = '0;
        end
    end

    always_comb begin
        w_full  = (r_count == CW'(DEPTH));
        w_pop   = (r_count != '0) && bus.io_out_ready;
        w_push  = bus.io_in_valid && (!w_full || w_pop);
        w_drop  = bus.io_in_valid && w_full && !w_pop;
        w_entry = {(w_entry_row == 4'd0), w_entry_row, w_sat, w_sat_data};
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            r_wr_ptr    <= '0;
            r_rd_ptr    <= '0;
            r_count     <= '0;
            r_row       <= '0;
            r_prev_prop <= 1'b0;
            r_overflow  <= 1'b0;
        end else begin
            if (w_push) begin
                r_wr_ptr <= r_wr_ptr + 1'b1;
            end
            if (w_pop) begin
                r_rd_ptr <= r_rd_ptr + 1'b1;
            end
            case ({w_push, w_pop})
                2'b10:   r_count <= r_count + 1'b1;
                2'b01:   r_count <= r_count - 1'b1;
                default: r_count <= r_count;
            endcase
            // Row tracking follows every valid input, dropped or not, so the
            // row tags stay aligned with the mesh after an overflow.
            if (bus.io_in_valid) begin
                r_row       <= w_next_row;
                r_prev_prop <= bus.io_in_control_propagate;
            end
            if (w_drop) begin
                r_overflow <= 1'b1;
            end
        end
    end

    // Storage is not reset; only the pointers/count define validity.
    always_ff @(posedge clock) begin
        if (!reset && w_push) begin
            r_mem[r_wr_ptr] <= w_entry;
        end
    end

    assign w_head                = r_mem[r_rd_ptr];
    assign bus.io_out_valid      = (r_count != '0);
    assign bus.io_out_bits_data  = w_head[31:0];
    assign bus.io_out_bits_sat   = w_head[32];
    assign bus.io_out_bits_row   = w_head[36:33];
    assign bus.io_out_bits_first = w_head[37];
    assign bus.io_overflow       = r_overflow;
    assign bus.io_count          = r_count;
endmodule

// File: tb/tb_tile_out_collector.sv
// ----------------------------------------------------------------------------
// tb_tile_out_collector
// Directed bench for tile_out_collector with DEPTH=4, ROWS=16. Inputs are
// driven 1 time unit after a rising edge and outputs are sampled at the same
// point, so each check sees the state produced by the preceding edge.
// ----------------------------------------------------------------------------
module tb_tile_out_collector;
    logic clock = 1'b0;
    logic reset;
    int   n_tests = 0;
    int   n_fail  = 0;

    always #5 clock = ~clock;

    tile_out_collector_if #(.DEPTH(4)) bus ();

    tile_out_collector #(.DEPTH(4), .ROWS(16)) dut (
        .clock (clock),
        .reset (reset),
        .bus   (bus)
    );

    task automatic tick;
        @(posedge clock);
        #1;
    endtask

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_tests++;
        assert (got === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic check_head(input string tag, input logic [31:0] d, input logic s,
                              input logic [3:0] r, input logic f);
        check({tag, "/valid"}, 64'(bus.io_out_valid), 64'(1'b1));
        check({tag, "/data"},  64'(bus.io_out_bits_data), 64'(d));
        check({tag, "/sat"},   64'(bus.io_out_bits_sat), 64'(s));
        check({tag, "/row"},   64'(bus.io_out_bits_row), 64'(r));
        check({tag, "/first"}, 64'(bus.io_out_bits_first), 64'(f));
    endtask

    task automatic push_one(input logic signed [135:0] c, input logic p);
        bus.io_in_c                 = c;
        bus.io_in_control_propagate = p;
        bus.io_in_valid             = 1'b1;
        tick();
        bus.io_in_valid             = 1'b0;
    endtask

    task automatic do_reset;
        reset = 1'b1;
        tick();
        tick();
        reset = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL timeout: simulation did not finish");
        $fatal(1);
    end

    initial begin
        logic signed [135:0] c;
        reset                       = 1'b1;
        bus.io_in_c                 = '0;
        bus.io_in_control_propagate = 1'b0;
        bus.io_in_valid             = 1'b0;
        bus.io_out_ready            = 1'b0;
        do_reset();

        // Reset state
        check("rst/valid",    64'(bus.io_out_valid), 64'(0));
        check("rst/count",    64'(bus.io_count), 64'(0));
        check("rst/overflow", 64'(bus.io_overflow), 64'(0));

        // Saturation, streaming with ready=1 (each entry pops as the next arrives)
        bus.io_out_ready = 1'b1;
        push_one(136'sd5, 1'b0);
        check_head("sat_5", 32'd5, 1'b0, 4'd0, 1'b1);
        push_one(136'sd1099511627776, 1'b0);
        check_head("sat_p2e40", 32'h7FFF_FFFF, 1'b1, 4'd1, 1'b0);
        c = -136'sd1099511627776;
        push_one(c, 1'b0);
        check_head("sat_n2e40", 32'h8000_0000, 1'b1, 4'd2, 1'b0);
        c = -136'sd2147483648;
        push_one(c, 1'b0);
        check_head("sat_n2e31", 32'h8000_0000, 1'b0, 4'd3, 1'b0);
        push_one(136'sd2147483647, 1'b0);
        check_head("sat_max", 32'h7FFF_FFFF, 1'b0, 4'd4, 1'b0);
        push_one(136'sd2147483648, 1'b0);
        check_head("sat_max1", 32'h7FFF_FFFF, 1'b1, 4'd5, 1'b0);
        check("sat/count", 64'(bus.io_count), 64'(1));

        // Row wrap over 18 entries
        do_reset();
        bus.io_out_ready = 1'b1;
        for (int i = 0; i < 18; i++) begin
            push_one(136'(i), 1'b0);
            check_head($sformatf("row%0d", i), 32'(i), 1'b0, 4'(i % 16), (i % 16) == 0);
        end

        // Propagate toggle restarts the block
        do_reset();
        bus.io_out_ready = 1'b1;
        push_one(136'sd100, 1'b0);
        check_head("tog0", 32'd100, 1'b0, 4'd0, 1'b1);
        push_one(136'sd101, 1'b0);
        check_head("tog1", 32'd101, 1'b0, 4'd1, 1'b0);
        push_one(136'sd102, 1'b0);
        check_head("tog2", 32'd102, 1'b0, 4'd2, 1'b0);
        push_one(136'sd103, 1'b1);
        check_head("tog3", 32'd103, 1'b0, 4'd0, 1'b1);

        // Overflow: 5 inputs into a 4-deep FIFO with no consumer
        do_reset();
        bus.io_out_ready = 1'b0;
        for (int i = 1; i <= 5; i++) begin
            push_one(136'(i), 1'b0);
        end
        check("ovf/count",    64'(bus.io_count), 64'(4));
        check("ovf/overflow", 64'(bus.io_overflow), 64'(1));
        bus.io_out_ready = 1'b1;
        for (int i = 1; i <= 4; i++) begin
            check_head($sformatf("ovf_drain%0d", i), 32'(i), 1'b0, 4'(i - 1), i == 1);
            tick();
        end
        check("ovf/empty_valid", 64'(bus.io_out_valid), 64'(0));
        tick();
        tick();
        check("ovf/no_underflow", 64'(bus.io_count), 64'(0));
        push_one(136'sd6, 1'b0);
        check_head("ovf_next", 32'd6, 1'b0, 4'd5, 1'b0);
        check("ovf/sticky", 64'(bus.io_overflow), 64'(1));
        tick();

        // Full FIFO with simultaneous push and pop
        do_reset();
        bus.io_out_ready = 1'b0;
        for (int i = 10; i <= 13; i++) begin
            push_one(136'(i), 1'b0);
        end
        check("pp/full_count", 64'(bus.io_count), 64'(4));
        bus.io_out_ready = 1'b1;
        push_one(136'sd14, 1'b0);
        check("pp/count",    64'(bus.io_count), 64'(4));
        check("pp/overflow", 64'(bus.io_overflow), 64'(0));
        for (int i = 11; i <= 14; i++) begin
            check_head($sformatf("pp_drain%0d", i), 32'(i), 1'b0, 4'(i - 10), 1'b0);
            tick();
        end
        check("pp/empty", 64'(bus.io_count), 64'(0));

        // Reset mid-stream, with overflow set and an input in the reset cycle
        do_reset();
        bus.io_out_ready = 1'b0;
        for (int i = 20; i <= 24; i++) begin
            push_one(136'(i), 1'b0);
        end
        bus.io_out_ready = 1'b1;
        tick();
        bus.io_out_ready = 1'b0;
        check("mid/count3",   64'(bus.io_count), 64'(3));
        check("mid/ovf_set",  64'(bus.io_overflow), 64'(1));
        reset                       = 1'b1;
        bus.io_in_c                 = 136'sd99;
        bus.io_in_control_propagate = 1'b1;
        bus.io_in_valid             = 1'b1;
        tick();
        reset           = 1'b0;
        bus.io_in_valid = 1'b0;
        check("mid/valid",    64'(bus.io_out_valid), 64'(0));
        check("mid/count",    64'(bus.io_count), 64'(0));
        check("mid/overflow", 64'(bus.io_overflow), 64'(0));
        push_one(136'sd25, 1'b0);
        check_head("mid_next", 32'd25, 1'b0, 4'd0, 1'b1);
        check("mid/count1", 64'(bus.io_count), 64'(1));

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
